// File: rtl/ami_rarb_pkg.sv
// ami_rarb_pkg: shared FSM state and AXI read-response encodings for the read arbiter
package ami_rarb_pkg;
  typedef enum logic {IDLE, HOLD} state_e;
  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_EXOKAY = 2'b01;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;
endpackage

// File: rtl/ami_rarb_if.sv
// ami_rarb_if: downstream AXI read-address and read-data channels of the arbiter
interface ami_rarb_if #(
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3
);
  logic [AXI_IW-1:0] ARID;
  logic [AXI_AW-1:0] ARADDR;
  logic [AXI_LW-1:0] ARLEN;
  logic [AXI_SW-1:0] ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic [AXI_IW-1:0] RID;
  logic [AXI_DW-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
  modport master(output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
                 input ARREADY, RID, RDATA, RRESP, RLAST, RVALID);
  modport slave(input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
                output ARREADY, RID, RDATA, RRESP, RLAST, RVALID);
endinterface

// File: rtl/ami_rarb_rr_pick.sv
// rr_pick: round-robin picker, searching from ptr+1 and wrapping modulo NREQ
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IXW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IXW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IXW-1:0]  gnt_idx
);
  // walk from the farthest candidate back to the nearest so the closest one wins
  always_comb begin
    int j;
    j = 0;
    gnt_oh = '0;
    gnt_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (req[j[IXW-1:0]]) begin
        gnt_idx = j[IXW-1:0];
        gnt_oh = NREQ'(1) << j[IXW-1:0];
      end
    end
  end
endmodule

// File: rtl/ami_rarb.sv
// ami_rarb: round-robin AXI read arbiter for NREQ requesters with ID-based R routing
// and a saturating outstanding-burst limit.
module ami_rarb
  import ami_rarb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int AXI_DW = 128,
  parameter int AXI_AW = 32,
  parameter int AXI_IW = 8,
  parameter int AXI_LW = 8,
  parameter int AXI_SW = 3,
  parameter int AMI_OD = 4,
  parameter int IXW    = $clog2(NREQ)
) (
  input  logic                                ACLK,
  input  logic                                ARESETn,
  input  logic [NREQ-1:0][AXI_IW-IXW-1:0]     req_arid,
  input  logic [NREQ-1:0][AXI_AW-1:0]         req_araddr,
  input  logic [NREQ-1:0][AXI_LW-1:0]         req_arlen,
  input  logic [NREQ-1:0][AXI_SW-1:0]         req_arsize,
  input  logic [NREQ-1:0][1:0]                req_arburst,
  input  logic [NREQ-1:0]                     req_arvalid,
  output logic [NREQ-1:0]                     req_arready,
  output logic [AXI_IW-IXW-1:0]               req_rid,
  output logic [AXI_DW-1:0]                   req_rdata,
  output logic [1:0]                          req_rresp,
  output logic                                req_rlast,
  output logic [NREQ-1:0]                     req_rvalid,
  input  logic [NREQ-1:0]                     req_rready,
  ami_rarb_if.master                          m,
  output logic [$clog2(AMI_OD+1)-1:0]         ost_cnt,
  output logic                                rid_err
);
  localparam int OW = $clog2(AMI_OD+1);
  state_e state_q, state_d;
  logic [IXW-1:0] gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, pick_idx, ridx;
  logic [NREQ-1:0] gnt_oh_q, gnt_oh_d, pick_oh, hit;
  logic [OW-1:0] ost_q, ost_d;
  logic rid_err_q, rid_err_d, hold, bad, ar_hs, r_hs, dec;

  rr_pick #(.NREQ(NREQ), .IXW(IXW)) u_pick (
    .req(req_arvalid), .ptr(rr_ptr_q), .gnt_oh(pick_oh), .gnt_idx(pick_idx)
  );

  // R routing: the top ID bits select the requester; unknown indices are sunk
  assign ridx = m.RID[AXI_IW-1 -: IXW];
  always_comb begin
    hit = '0;
    for (int i = 0; i < NREQ; i++) hit[i] = ridx == IXW'(i);
  end
  assign bad = ~|hit;
  assign req_rvalid = hit & {NREQ{m.RVALID}};
  assign m.RREADY = bad | |(hit & req_rready);
  assign req_rid = m.RID[AXI_IW-IXW-1:0];
  assign req_rdata = m.RDATA;
  assign req_rresp = m.RRESP;
  assign req_rlast = m.RLAST;

  assign hold = state_q == HOLD;
  assign m.ARVALID = hold;
  assign m.ARID = {gnt_q, req_arid[gnt_q]};
  assign m.ARADDR = req_araddr[gnt_q];
  assign m.ARLEN = req_arlen[gnt_q];
  assign m.ARSIZE = req_arsize[gnt_q];
  assign m.ARBURST = req_arburst[gnt_q];
  assign req_arready = gnt_oh_q & {NREQ{hold && m.ARREADY}};
  assign ar_hs = hold && m.ARREADY;
  assign r_hs = m.RVALID && m.RREADY;
  assign dec = r_hs && m.RLAST && ost_q != '0;
  assign ost_cnt = ost_q;
  assign rid_err = rid_err_q;

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    gnt_oh_d = gnt_oh_q;
    rr_ptr_d = rr_ptr_q;
    ost_d = ost_q + OW'(ar_hs) - OW'(dec);
    rid_err_d = r_hs && (bad || (m.RLAST && ost_q == '0));
    if (!hold && |req_arvalid && ost_q < OW'(AMI_OD)) begin
      state_d = HOLD;
      gnt_d = pick_idx;
      gnt_oh_d = pick_oh;
    end else if (ar_hs) begin
      state_d = IDLE;
      rr_ptr_d = gnt_q;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      gnt_q <= '0;
      gnt_oh_q <= '0;
      rr_ptr_q <= IXW'(NREQ-1);
      ost_q <= '0;
      rid_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      rr_ptr_q <= rr_ptr_d;
      ost_q <= ost_d;
      rid_err_q <= rid_err_d;
    end
  end
endmodule

// File: tb/tb_ami_rarb.sv
// tb_ami_rarb: directed scenarios plus randomized traffic checked against a
// transaction-level model of grant order, routing and outstanding count.
module tb_ami_rarb;
  import ami_rarb_pkg::*;
  localparam int NREQ = 4, DW = 128, AW = 32, IW = 8, LW = 8, SW = 3, OD = 4;
  localparam int IXW = 2, RW = IW - IXW, OW = 3, N3 = 3;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  logic [NREQ-1:0][RW-1:0] req_arid;
  logic [NREQ-1:0][AW-1:0] req_araddr;
  logic [NREQ-1:0][LW-1:0] req_arlen;
  logic [NREQ-1:0][SW-1:0] req_arsize;
  logic [NREQ-1:0][1:0] req_arburst;
  logic [NREQ-1:0] req_arvalid, req_arready, req_rvalid, req_rready;
  logic [RW-1:0] req_rid;
  logic [DW-1:0] req_rdata;
  logic [1:0] req_rresp;
  logic req_rlast, rid_err;
  logic [OW-1:0] ost_cnt;

  logic [N3-1:0][RW-1:0] r3_arid;
  logic [N3-1:0][AW-1:0] r3_araddr;
  logic [N3-1:0][LW-1:0] r3_arlen;
  logic [N3-1:0][SW-1:0] r3_arsize;
  logic [N3-1:0][1:0] r3_arburst;
  logic [N3-1:0] r3_arvalid, r3_arready, r3_rvalid, r3_rready;
  logic [RW-1:0] r3_rid;
  logic [DW-1:0] r3_rdata;
  logic [1:0] r3_rresp;
  logic r3_rlast, err3;
  logic [OW-1:0] ost3;

  ami_rarb_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW)) bus ();
  ami_rarb_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW), .AXI_SW(SW)) bus3 ();

  ami_rarb #(.NREQ(NREQ), .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW),
             .AXI_SW(SW), .AMI_OD(OD)) dut (
    .ACLK(clk), .ARESETn(rst_n), .req_arid(req_arid), .req_araddr(req_araddr),
    .req_arlen(req_arlen), .req_arsize(req_arsize), .req_arburst(req_arburst),
    .req_arvalid(req_arvalid), .req_arready(req_arready), .req_rid(req_rid),
    .req_rdata(req_rdata), .req_rresp(req_rresp), .req_rlast(req_rlast),
    .req_rvalid(req_rvalid), .req_rready(req_rready), .m(bus.master),
    .ost_cnt(ost_cnt), .rid_err(rid_err)
  );

  ami_rarb #(.NREQ(N3), .AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW),
             .AXI_SW(SW), .AMI_OD(OD)) dut3 (
    .ACLK(clk), .ARESETn(rst_n), .req_arid(r3_arid), .req_araddr(r3_araddr),
    .req_arlen(r3_arlen), .req_arsize(r3_arsize), .req_arburst(r3_arburst),
    .req_arvalid(r3_arvalid), .req_arready(r3_arready), .req_rid(r3_rid),
    .req_rdata(r3_rdata), .req_rresp(r3_rresp), .req_rlast(r3_rlast),
    .req_rvalid(r3_rvalid), .req_rready(r3_rready), .m(bus3.master),
    .ost_cnt(ost3), .rid_err(err3)
  );

  int n_tests = 0, n_fail = 0;
  int m_gnt, m_last, m_ost, last_hs;
  bit m_err;
  int gq[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic new_payload(input int i);
    req_arid[i] = RW'($urandom);
    req_araddr[i] = $urandom;
    req_arlen[i] = LW'($urandom);
    req_arsize[i] = SW'($urandom);
    req_arburst[i] = 2'($urandom);
  endtask

  task automatic idle_in();
    req_arvalid = '0;
    req_rready = '0;
    bus.ARREADY = 0;
    bus.RVALID = 0;
    bus.RID = '0;
    bus.RDATA = '0;
    bus.RRESP = RRESP_OKAY;
    bus.RLAST = 0;
    r3_arvalid = '0;
    r3_rready = '0;
    bus3.ARREADY = 0;
    bus3.RVALID = 0;
    bus3.RID = '0;
    bus3.RDATA = '0;
    bus3.RRESP = RRESP_OKAY;
    bus3.RLAST = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    m_gnt = -1;
    m_last = NREQ - 1;
    m_ost = 0;
    m_err = 0;
    last_hs = -1;
    gq.delete();
    chk("rst_arvalid", bus.ARVALID, 0);
    chk("rst_arready", req_arready, 0);
    chk("rst_ost", ost_cnt, 0);
    chk("rst_err", rid_err, 0);
  endtask

  // Check one cycle against the model, then advance the model and the clock.
  task automatic cyc();
    int idx, nxt;
    bit bad, ex_rready, ar_hs, r_hs, dec, nerr;
    logic [NREQ-1:0] ex_rvalid, ex_arready;
    #1;
    idx = int'(bus.RID[IW-1 -: IXW]);
    bad = idx >= NREQ;
    ex_rvalid = (!bad && bus.RVALID) ? NREQ'(1) << idx : '0;
    ex_rready = bad ? 1'b1 : req_rready[idx];
    ex_arready = (m_gnt >= 0 && bus.ARREADY) ? NREQ'(1) << m_gnt : '0;
    chk("arvalid", bus.ARVALID, m_gnt >= 0);
    if (m_gnt >= 0) begin
      chk("arid", bus.ARID, {IXW'(m_gnt), req_arid[m_gnt]});
      chk("araddr", bus.ARADDR, req_araddr[m_gnt]);
      chk("arlen", bus.ARLEN, req_arlen[m_gnt]);
      chk("arsize_burst", {bus.ARSIZE, bus.ARBURST}, {req_arsize[m_gnt], req_arburst[m_gnt]});
    end
    chk("req_arready", req_arready, ex_arready);
    chk("req_rvalid", req_rvalid, ex_rvalid);
    chk("rready", bus.RREADY, ex_rready);
    chk("req_rid", req_rid, bus.RID[RW-1:0]);
    chk("r_pass", {req_rdata, req_rresp, req_rlast}, {bus.RDATA, bus.RRESP, bus.RLAST});
    chk("ost_cnt", ost_cnt, m_ost);
    chk("rid_err", rid_err, m_err);
    ar_hs = m_gnt >= 0 && bus.ARREADY;
    r_hs = bus.RVALID && ex_rready;
    dec = r_hs && bus.RLAST && m_ost > 0;
    nerr = r_hs && (bad || (bus.RLAST && m_ost == 0));
    last_hs = -1;
    if (ar_hs) begin
      gq.push_back(m_gnt);
      last_hs = m_gnt;
      m_last = m_gnt;
      m_gnt = -1;
    end else if (m_gnt < 0 && m_ost < OD) begin
      for (int k = 1; k <= NREQ; k++) begin
        nxt = (m_last + k) % NREQ;
        if (m_gnt < 0 && req_arvalid[nxt]) m_gnt = nxt;
      end
    end
    m_ost = m_ost + int'(ar_hs) - int'(dec);
    m_err = nerr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic t_nreq3();
    r3_arvalid = 3'b001;
    bus3.ARREADY = 1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    r3_arvalid = '0;
    chk("n3_ost1", ost3, 1);
    bus3.RVALID = 1;
    bus3.RID = {2'd3, 6'h11};
    bus3.RLAST = 1;
    #1;
    chk("n3_rready", bus3.RREADY, 1);
    chk("n3_rvalid", r3_rvalid, 0);
    @(posedge clk);
    @(negedge clk);
    bus3.RVALID = 0;
    bus3.RLAST = 0;
    chk("n3_err", err3, 1);
    chk("n3_ost0", ost3, 0);
    @(posedge clk);
    @(negedge clk);
    chk("n3_err_clr", err3, 0);
  endtask

  task automatic rand_phase(input int cycles, input int ar_pct, input int last_pct);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (i == last_hs || !req_arvalid[i]) begin
          req_arvalid[i] = 0;
          if ($urandom_range(0, 2) == 0) begin
            new_payload(i);
            req_arvalid[i] = 1;
          end
        end
      bus.ARREADY = $urandom_range(0, 99) < ar_pct;
      bus.RVALID = $urandom_range(0, 1) == 1;
      bus.RID = IW'($urandom);
      bus.RDATA = {$urandom, $urandom, $urandom, $urandom};
      bus.RRESP = 2'($urandom);
      bus.RLAST = $urandom_range(0, 99) < last_pct;
      req_rready = NREQ'($urandom);
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) new_payload(i);
    for (int i = 0; i < N3; i++) begin
      r3_arid[i] = RW'(i + 1);
      r3_araddr[i] = 32'h1000 * (i + 1);
      r3_arlen[i] = 8'd3;
      r3_arsize[i] = 3'd4;
      r3_arburst[i] = 2'd1;
    end
    do_reset();
    t_nreq3();

    do_reset();
    req_arvalid = 4'b0001;
    bus.ARREADY = 1;
    cyc();
    chk("r24_arvalid", bus.ARVALID, 1);
    chk("r24_arid", bus.ARID, {2'b00, req_arid[0]});
    cyc();
    req_arvalid = '0;
    chk("r24_ost", ost_cnt, 1);
    cyc();

    do_reset();
    req_arvalid = '1;
    bus.ARREADY = 1;
    repeat (12) cyc();
    chk("r26_full", ost_cnt, 4);
    chk("r26_ngrant", gq.size(), 4);
    bus.RVALID = 1;
    bus.RLAST = 1;
    bus.RID = {2'd1, 6'h0};
    req_rready = '1;
    cyc();
    bus.RVALID = 0;
    bus.RLAST = 0;
    chk("r26_ost3", ost_cnt, 3);
    repeat (2) cyc();
    chk("r26_ost4", ost_cnt, 4);
    chk("r25_ngrant", gq.size(), 5);
    for (int i = 0; i < 5; i++) chk("r25_order", (gq.size() > i) ? gq[i] : -1, i % 4);

    do_reset();
    bus.RVALID = 1;
    bus.RID = {2'd2, 6'h05};
    #1;
    chk("r27_rready0", bus.RREADY, 0);
    chk("r27_rvalid", req_rvalid, 4'b0100);
    req_rready[2] = 1;
    #1;
    chk("r27_rready1", bus.RREADY, 1);
    chk("r27_rid", req_rid, 6'h05);
    cyc();
    bus.RVALID = 0;

    do_reset();
    req_arvalid = 4'b0011;
    bus.ARREADY = 1;
    repeat (4) cyc();
    chk("r28_pre", ost_cnt, 2);
    bus.ARREADY = 0;
    cyc();
    bus.ARREADY = 1;
    bus.RVALID = 1;
    bus.RLAST = 1;
    bus.RID = '0;
    req_rready = '1;
    cyc();
    chk("r28_ost", ost_cnt, 2);

    do_reset();
    req_arvalid = 4'b0100;
    cyc();
    chk("hold_arvalid", bus.ARVALID, 1);
    bus.ARREADY = 1;
    rst_n = 0;
    #1;
    chk("arst_arvalid", bus.ARVALID, 0);
    chk("arst_arready", req_arready, 0);

    do_reset();
    rand_phase(1500, 50, 25);
    rand_phase(1500, 12, 60);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ami_rarb.md
AMI_RARB -- requirements
Module: ami_rarb

Interface
REQ-001 Parameters SHALL be: NREQ, 4, number of requesters (2..8); AXI_DW, 128, data width; AXI_AW, 32, address width; AXI_IW, 8, ID width; AXI_LW, 8, len width; AXI_SW, 3, size width; AMI_OD, 4, max total outstanding bursts; IXW, $clog2(NREQ), derived requester index width.
REQ-002 Clocking SHALL be one clock and one asynchronous active-low reset: ACLK  in  1  clock; ARESETn  in  1  async active-low reset.
REQ-003 Requester AR ports SHALL be: req_arid  in  NREQ x (AXI_IW-IXW)  ID; req_araddr  in  NREQ x AXI_AW; req_arlen  in  NREQ x AXI_LW; req_arsize  in  NREQ x AXI_SW; req_arburst  in  NREQ x 2; req_arvalid  in  NREQ; req_arready  out  NREQ.
REQ-004 Requester R ports SHALL be: req_rid  out  AXI_IW-IXW; req_rdata  out  AXI_DW; req_rresp  out  2; req_rlast  out  1 (all shared); req_rvalid  out  NREQ; req_rready  in  NREQ.
REQ-005 Master ports SHALL be AXI AR (ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID out; ARREADY in) and R (RID, RDATA, RRESP, RLAST, RVALID in; RREADY out), widths as parameters.
REQ-006 Status ports SHALL be: ost_cnt  out  $clog2(AMI_OD+1)  outstanding bursts; rid_err  out  1  one-cycle pulse on misrouted R beat.

Function
REQ-007 AR arbitration SHALL be round-robin over req_arvalid, search starting at index rr_ptr+1 mod NREQ.
REQ-008 FSM SHALL have states IDLE and HOLD; IDLE->HOLD when any req_arvalid=1 and ost_cnt<AMI_OD, latching winner index gnt.
REQ-009 In HOLD, ARVALID SHALL be 1 and AR payload SHALL come from requester gnt, unchanged until handshake.
REQ-010 ARID SHALL be {gnt, req_arid[gnt]} (index in top IXW bits).
REQ-011 req_arready[gnt] SHALL equal ARREADY in HOLD; all other req_arready bits SHALL be 0.
REQ-012 On ARVALID&ARREADY: rr_ptr<=gnt, ost_cnt increments, FSM->IDLE (one idle cycle between grants).
REQ-013 ARVALID SHALL never assert in IDLE; a grant SHALL NOT be issued while ost_cnt==AMI_OD.
REQ-014 Once in HOLD, the grant SHALL NOT be revoked even if req_arvalid[gnt] drops (protocol violation, requester's fault).
REQ-015 R routing SHALL be combinational: idx=RID[AXI_IW-1 -: IXW]; req_rvalid[idx]=RVALID; RREADY=req_rready[idx]; req_rid=RID[AXI_IW-IXW-1:0]; data/resp/last pass through.
REQ-016 If idx>=NREQ, RREADY SHALL be 1 (beat discarded), no req_rvalid asserted, rid_err pulses for each such beat.
REQ-017 ost_cnt SHALL decrement on RVALID&RREADY&RLAST, including discarded beats; simultaneous AR handshake and RLAST handshake SHALL leave it unchanged.
REQ-018 ost_cnt SHALL saturate: no decrement at 0 (RLAST with ost_cnt=0 also pulses rid_err); never exceeds AMI_OD.
REQ-019 AR grant and R routing SHALL be independent; R beats for any requester flow in the same cycle as an AR handshake.

Reset
REQ-020 On ARESETn=0 asynchronously: FSM=IDLE, ARVALID=0, req_arready=0, rr_ptr=NREQ-1 (index 0 wins first), gnt=0, ost_cnt=0, rid_err=0.
REQ-021 Reset mid-HOLD SHALL drop ARVALID immediately; in-flight R bursts are lost; no recovery logic.

Structure
REQ-022 A shared package SHALL hold the FSM state enum (IDLE, HOLD) and the RRESP encodings.
REQ-023 The round-robin priority picker SHALL be one sub-module, rr_pick (inputs req vector and pointer; outputs one-hot grant and index).

Verification
REQ-024 Reset, then req_arvalid=4'b0001, ARREADY=1 -> ARVALID at cycle 2, ARID=0x00|req_arid[0], ost_cnt=1.
REQ-025 All four req_arvalid held high, ARREADY=1 -> grant order 0,1,2,3,0; one idle cycle between handshakes.
REQ-026 Issue 4 ARs with no R returned -> ost_cnt=4, fifth request never sees ARVALID; one RLAST beat -> ost_cnt=3, fifth granted next IDLE.
REQ-027 RID={2'd2,6'h05}, RVALID=1, req_rready[2]=0 -> RREADY=0, req_rvalid=4'b0100; raise req_rready[2] -> RREADY=1, req_rid=6'h05.
REQ-028 AR handshake and RLAST handshake in the same cycle at ost_cnt=2 -> ost_cnt stays 2.
REQ-029 NREQ=3, RID top bits=2'd3, RLAST=1 -> RREADY=1, req_rvalid=0, rid_err pulses one cycle, ost_cnt decrements.
